// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, receiver state encoding and baud divider helper
package uart_pkg;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      return clk_freq / (baud * os);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO whose head word and empty flag are registered
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic do_wr, do_rd;
   // a write into the slot that becomes head must bypass the array
   always_comb begin
      do_rd = rd_en & ~empty;
      do_wr = wr_en & (~full | do_rd);
      rd_nxt = rd_ptr + AW'(do_rd);
      cnt_nxt = cnt + CW'(do_wr) - CW'(do_rd);
      head_nxt = cnt_nxt == '0 ? '0 : (do_wr && wr_ptr == rd_nxt) ? wr_data : mem[rd_nxt];
   end
   assign full = cnt == CW'(DEPTH);
   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
         rd_data <= '0;
         empty <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_wr);
         rd_ptr <= rd_nxt;
         cnt <= cnt_nxt;
         rd_data <= head_nxt;
         empty <= cnt_nxt == '0;
      end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with majority vote, break detect and output FIFO
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 1,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_perr,
   output logic                 out_ferr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun,
   output logic                 break_det,
   output logic                 busy
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int DW = $clog2(DIV + 1);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int H = OVERSAMPLE / 2;
   state_t state, nxt;
   logic rx_s1, rx_s2, rx_d;
   logic [DW-1:0] div_cnt;
   logic [TW-1:0] tick_cnt, hi_cnt;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS+1:0] rd_data;
   logic stop_cnt, s0, s1, pbit, perr, ferr;
   logic tick, dec, bend, start_edge, maj, last_stop, brk, par_exp, wr, full, empty;
   assign tick = div_cnt == DW'(DIV - 1);
   assign dec = tick && tick_cnt == TW'(H);
   assign bend = tick && tick_cnt == TW'(OVERSAMPLE - 1);
   assign start_edge = state == ST_IDLE && rx_d && !rx_s2;
   assign maj = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
   assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
   assign brk = shreg == '0 && !pbit && !maj;
   assign par_exp = PARITY == PARITY_ODD ? ~^shreg : ^shreg;
   // the last stop bit is resolved at its decision tick so the next start edge is caught early
   always_comb begin
      nxt = state;
      wr = 1'b0;
      case (state)
         ST_IDLE:   nxt = start_edge ? ST_START : ST_IDLE;
         ST_START:  nxt = dec && maj ? ST_IDLE : bend ? ST_DATA : ST_START;
         ST_DATA:   nxt = bend && bit_cnt == BW'(DATA_BITS) ?
                          (PARITY != PARITY_NONE ? ST_PARITY : ST_STOP) : ST_DATA;
         ST_PARITY: nxt = bend ? ST_STOP : ST_PARITY;
         ST_STOP: begin
            if (dec && last_stop) begin
               nxt = brk ? ST_BREAK : ST_IDLE;
               wr = !brk;
            end
         end
         ST_BREAK:  nxt = tick && rx_s2 && hi_cnt == TW'(OVERSAMPLE - 1) ? ST_IDLE : ST_BREAK;
         default:   nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d <= 1'b1;
         state <= ST_IDLE;
         div_cnt <= '0;
         tick_cnt <= '0;
         hi_cnt <= '0;
         bit_cnt <= '0;
         stop_cnt <= 1'b0;
         shreg <= '0;
         s0 <= 1'b0;
         s1 <= 1'b0;
         pbit <= 1'b0;
         perr <= 1'b0;
         ferr <= 1'b0;
         overrun <= 1'b0;
         break_det <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d <= rx_s2;
         state <= nxt;
         overrun <= wr && full && !(out_ready && !empty);
         break_det <= state != ST_BREAK && nxt == ST_BREAK;
         if (start_edge) begin
            div_cnt <= '0;
            tick_cnt <= '0;
         end else if (tick) begin
            div_cnt <= '0;
            tick_cnt <= bend ? '0 : tick_cnt + 1'b1;
         end else
            div_cnt <= div_cnt + 1'b1;
         hi_cnt <= (state != ST_BREAK || !rx_s2) ? '0 : tick ? hi_cnt + 1'b1 : hi_cnt;
         if (tick && tick_cnt == TW'(H - 2)) s0 <= rx_s2;
         if (tick && tick_cnt == TW'(H - 1)) s1 <= rx_s2;
         if (start_edge) begin
            bit_cnt <= '0;
            stop_cnt <= 1'b0;
            shreg <= '0;
            pbit <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
         end else if (dec) begin
            if (state == ST_DATA) begin
               shreg <= {maj, shreg[DATA_BITS-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_PARITY) begin
               pbit <= maj;
               perr <= maj != par_exp;
            end
            if (state == ST_STOP) ferr <= ferr | ~maj;
         end
         if (bend && state == ST_STOP) stop_cnt <= 1'b1;
      end
   sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .wr_en(wr),
      .wr_data({perr, ferr | ~maj, shreg}),
      .rd_en(out_ready),
      .rd_data(rd_data),
      .full(full),
      .empty(empty)
   );
   assign out_data = rd_data[DATA_BITS-1:0];
   assign out_ferr = rd_data[DATA_BITS];
   assign out_perr = rd_data[DATA_BITS+1];
   assign out_valid = ~empty;
   assign busy = state != ST_IDLE;
endmodule
